sfp_i2c_block_reader: RTL

SFP_I2C_BLOCK_READER -- requirements
Module: sfp_i2c_block_reader

---
 rtl/sfp_i2c_block_reader_pkg.sv | 30 +++
 rtl/sfp_i2c_block_reader_rd_watchdog.sv | 38 +++
 rtl/sfp_i2c_block_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sfp_i2c_block_reader_pkg.sv
// Shared definitions for the SFP EEPROM block reader: one-hot state layout,
// block size and default device/offset/watchdog settings.
package sfp_i2c_block_reader_pkg;

    localparam int IDX_IDLE   = 0;
    localparam int IDX_REQ    = 1;
    localparam int IDX_WAIT   = 2;
    localparam int IDX_STORE  = 3;
    localparam int IDX_NEXT   = 4;
    localparam int IDX_DONE   = 5;
    localparam int IDX_ERROR  = 6;
    localparam int NUM_STATES = 7;

    localparam int NUM_BYTES = 16;

    localparam logic [6:0]  DEFAULT_DEV_ADDR       = 7'h50;
    localparam logic [7:0]  DEFAULT_START_OFFSET   = 8'd20;
    localparam logic [23:0] DEFAULT_TIMEOUT_CYCLES = 24'd1250000;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE  = 7'b000_0001,
        ST_REQ   = 7'b000_0010,
        ST_WAIT  = 7'b000_0100,
        ST_STORE = 7'b000_1000,
        ST_NEXT  = 7'b001_0000,
        ST_DONE  = 7'b010_0000,
        ST_ERROR = 7'b100_0000
    } state_e;

endpackage

// File: rtl/sfp_i2c_block_reader_rd_watchdog.sv
// Per-byte watchdog for the SFP block reader. Reloads when a byte request
// starts, counts down while the byte is outstanding and flags expiry at zero.
module sfp_rd_watchdog
    import sfp_i2c_block_reader_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);

    logic [23:0] count_q, count_d;

    // Reload on a new request, otherwise count down while a byte is in flight.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = TIMEOUT_CYCLES;
        end else if (run_i && (count_q != 24'd0)) begin
            count_d = count_q - 24'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = run_i && (count_q == 24'd0);

endmodule

// File: rtl/sfp_i2c_block_reader.sv
// Reads a 16-byte block from the SFP EEPROM one byte at a time through a
// byte-level I2C master and presents it as a 128-bit word (first byte in the
// MSBs). Defining SFP_RD_TIMEOUT_EN adds a per-byte watchdog that aborts a
// stalled byte into the error path.
module sfp_i2c_block_reader
    import sfp_i2c_block_reader_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = DEFAULT_DEV_ADDR,
    parameter logic [7:0]  START_OFFSET   = DEFAULT_START_OFFSET,
    parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_read_sfp,
    output logic         i2c_lines_busy,
    output logic         rd_req,
    output logic [6:0]   rd_dev_addr,
    output logic [7:0]   rd_reg_addr,
    input  logic         rd_ack,
    input  logic         rd_done,
    input  logic [7:0]   rd_data,
    input  logic         rd_nack,
    output logic [127:0] i2c_reg_sfp_dat,
    output logic         i2c_reg_sfp_valid,
    output logic         i2c_error
);

    state_e         state_q, state_d;
    logic [3:0]     byteCnt_q, byteCnt_d;
    logic [127:0]   shadow_q, shadow_d;
    logic [127:0]   blockDat_q, blockDat_d;
    logic [7:0]     regAddr_q, regAddr_d;
    logic           rdReq_q, rdReq_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           error_q, error_d;
    logic           timeoutHit;

`ifdef SFP_RD_TIMEOUT_EN
    logic wdLoad;
    logic wdRun;

    assign wdLoad = state_d[IDX_REQ] & ~state_q[IDX_REQ];
    assign wdRun  = state_q[IDX_REQ] | state_q[IDX_WAIT];

    sfp_rd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clk      (clk),
        .reset    (reset),
        .load_i   (wdLoad),
        .run_i    (wdRun),
        .expired_o(timeoutHit)
    );
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
    assign timeoutHit       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a timeout beats ack/done and a NACK beats a done.
    always_comb begin
        state_d = state_q;
        case (1'b1)
            state_q[IDX_IDLE]:  if (start_read_sfp) state_d = ST_REQ;
            state_q[IDX_REQ]: begin
                if (timeoutHit)  state_d = ST_ERROR;
                else if (rd_ack) state_d = ST_WAIT;
            end
            state_q[IDX_WAIT]: begin
                if (timeoutHit || rd_nack) state_d = ST_ERROR;
                else if (rd_done)          state_d = ST_STORE;
            end
            state_q[IDX_STORE]: state_d = ST_NEXT;
            state_q[IDX_NEXT]: begin
                if (byteCnt_q < 4'(NUM_BYTES - 1)) state_d = ST_REQ;
                else                               state_d = ST_DONE;
            end
            state_q[IDX_DONE]:  state_d = ST_IDLE;
            state_q[IDX_ERROR]: state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Output and datapath decode from the next state so every output is registered.
    always_comb begin
        byteCnt_d  = byteCnt_q;
        shadow_d   = shadow_q;
        blockDat_d = blockDat_q;
        if (state_q[IDX_STORE]) begin
            shadow_d[7'd127 - {byteCnt_q, 3'b000} -: 8] = rd_data;
        end
        if (state_d[IDX_IDLE]) begin
            byteCnt_d = '0;
        end else if (state_q[IDX_NEXT] && state_d[IDX_REQ]) begin
            byteCnt_d = byteCnt_q + 4'd1;
        end
        if (state_d[IDX_DONE]) begin
            blockDat_d = shadow_q;
        end
        rdReq_d   = state_d[IDX_REQ];
        busy_d    = ~state_d[IDX_IDLE];
        valid_d   = state_d[IDX_DONE];
        error_d   = state_d[IDX_ERROR];
        regAddr_d = START_OFFSET + {4'd0, byteCnt_d};
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            byteCnt_q  <= '0;
            shadow_q   <= '0;
            blockDat_q <= '0;
            regAddr_q  <= '0;
            rdReq_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            byteCnt_q  <= byteCnt_d;
            shadow_q   <= shadow_d;
            blockDat_q <= blockDat_d;
            regAddr_q  <= regAddr_d;
            rdReq_q    <= rdReq_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign i2c_lines_busy    = busy_q;
    assign rd_req            = rdReq_q;
    assign rd_dev_addr       = DEV_ADDR;
    assign rd_reg_addr       = regAddr_q;
    assign i2c_reg_sfp_dat   = blockDat_q;
    assign i2c_reg_sfp_valid = valid_q;
    assign i2c_error         = error_q;

endmodule
